// File: rtl/vpu_pathway_sequencer.sv
// ----------------------------------------------------------------------------
// vpu_pathway_sequencer
//   Command-driven sequencer for the VPU pipe_register chain. One command
//   carries a stage-enable mask and a vector count. The mask is held on
//   o_stage_en while the command is active. Exactly cmd_len vectors are
//   admitted from the systolic array. Vectors leaving the last pipe stage are
//   counted, and o_done pulses for one cycle after the final one. Protocol
//   violations and drain timeouts are flagged with sticky error bits.
//
// Ports
//   i_clk, i_rst              clock (rising edge), async active-high reset
//   i_cmd_valid / o_cmd_ready command handshake (ready only while idle)
//   i_cmd_mask, i_cmd_len     stage-enable mask and vector count of a command
//   i_in_vld / o_in_accept    vector offered / admitted into stage 0 (comb)
//   i_pipe_out_vld            out_vld of the last pipe stage
//   o_stage_en                registered mask driven to the datapath
//   o_busy, o_done            not idle / one-cycle completion pulse
//   o_err_protocol            sticky protocol error, cleared on next command
//   o_err_timeout             sticky drain watchdog error, cleared likewise
// ----------------------------------------------------------------------------
module vpu_pathway_sequencer #(
  parameter int NUM_STAGES = 4,
  parameter int CNT_W      = 16,
  parameter int TIMEOUT    = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [NUM_STAGES-1:0] i_cmd_mask,
  input  logic [CNT_W-1:0]      i_cmd_len,
  input  logic                  i_in_vld,
  output logic                  o_in_accept,
  input  logic                  i_pipe_out_vld,
  output logic [NUM_STAGES-1:0] o_stage_en,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err_protocol,
  output logic                  o_err_timeout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Watchdog fires on the idle DRAIN cycle whose count equals TIMEOUT-1.
  localparam bit               LP_WDOG_EN  = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] LP_IDLE_MAX = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : {CNT_W{1'b0}};

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_len;
  logic [CNT_W-1:0]      r_in_cnt;
  logic [CNT_W-1:0]      r_out_cnt;
  logic [CNT_W-1:0]      r_idle_cnt;
  logic [NUM_STAGES-1:0] r_stage_en;
  logic                  r_err_protocol;
  logic                  r_err_timeout;

  logic                  w_cmd_acc;
  logic                  w_in_inc;
  logic                  w_out_inc;
  logic                  w_in_last;
  logic                  w_out_last;
  logic                  w_timeout_hit;
  logic                  w_proto_viol;

  // Event decode: handshakes, counter increments and completion conditions.
  always_comb begin
    w_cmd_acc     = i_cmd_valid && (r_state == S_IDLE);
    w_in_inc      = i_in_vld && (r_state == S_RUN) && (r_in_cnt < r_len);
    w_out_inc     = i_pipe_out_vld && ((r_state == S_RUN) || (r_state == S_DRAIN))
                    && (r_out_cnt < r_len);
    // Counters never pass r_len, so +1 cannot overflow here.
    w_in_last     = w_in_inc  && ((r_in_cnt  + CNT_W'(1)) == r_len);
    w_out_last    = w_out_inc && ((r_out_cnt + CNT_W'(1)) == r_len);
    w_timeout_hit = LP_WDOG_EN && (r_state == S_DRAIN) && !i_pipe_out_vld
                    && (r_idle_cnt == LP_IDLE_MAX);
    // Any offer that is not counted is a violation: covers wrong state,
    // overrun beyond len, and outputs after the final vector.
    w_proto_viol  = (i_in_vld && !w_in_inc) || (i_pipe_out_vld && !w_out_inc);
  end

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic; output completion wins over input completion so a
  // zero-latency pathway goes straight from RUN to DONE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_cmd_acc) begin
          w_state_nxt = (i_cmd_len == {CNT_W{1'b0}}) ? S_DONE : S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_out_last) begin
          w_state_nxt = S_DONE;
        end else if (w_in_last) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_DRAIN: begin
        if (w_out_last || w_timeout_hit) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM output decode from the state register, plus the comb admit strobe.
  always_comb begin
    o_cmd_ready = (r_state == S_IDLE);
    o_busy      = (r_state != S_IDLE);
    o_done      = (r_state == S_DONE);
    o_in_accept = w_in_inc;
  end

  // Command registers, counters, stage mask and sticky error flags.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_len          <= {CNT_W{1'b0}};
      r_in_cnt       <= {CNT_W{1'b0}};
      r_out_cnt      <= {CNT_W{1'b0}};
      r_idle_cnt     <= {CNT_W{1'b0}};
      r_stage_en     <= {NUM_STAGES{1'b0}};
      r_err_protocol <= 1'b0;
      r_err_timeout  <= 1'b0;
    end else if (w_cmd_acc) begin
      r_len          <= i_cmd_len;
      r_in_cnt       <= {CNT_W{1'b0}};
      r_out_cnt      <= {CNT_W{1'b0}};
      r_idle_cnt     <= {CNT_W{1'b0}};
      r_stage_en     <= i_cmd_mask;
      r_err_protocol <= 1'b0;
      r_err_timeout  <= 1'b0;
    end else begin
      if (w_in_inc) begin
        r_in_cnt <= r_in_cnt + CNT_W'(1);
      end
      if (w_out_inc) begin
        r_out_cnt <= r_out_cnt + CNT_W'(1);
      end
      // Idle run length only matters in DRAIN; saturate so a disabled
      // watchdog cannot wrap it.
      if (r_state == S_DRAIN) begin
        if (i_pipe_out_vld) begin
          r_idle_cnt <= {CNT_W{1'b0}};
        end else if (r_idle_cnt != {CNT_W{1'b1}}) begin
          r_idle_cnt <= r_idle_cnt + CNT_W'(1);
        end
      end
      if (w_proto_viol) begin
        r_err_protocol <= 1'b1;
      end
      if (w_timeout_hit) begin
        r_err_timeout <= 1'b1;
      end
      if (r_state == S_DONE) begin
        r_stage_en <= {NUM_STAGES{1'b0}};
      end
    end
  end

  assign o_stage_en     = r_stage_en;
  assign o_err_protocol = r_err_protocol;
  assign o_err_timeout  = r_err_timeout;

endmodule

// File: tb/tb_vpu_pathway_sequencer.sv
// ----------------------------------------------------------------------------
// tb_vpu_pathway_sequencer
//   Directed scenarios followed by randomized traffic. A behavioural model of
//   the command lifecycle (phase, vectors in/out, idle run length) predicts
//   every output; one process compares on each falling clock edge.
// ----------------------------------------------------------------------------
module tb_vpu_pathway_sequencer;

  localparam int TO = 8;

  localparam int P_IDLE  = 0;
  localparam int P_RUN   = 1;
  localparam int P_DRAIN = 2;
  localparam int P_DONE  = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready_o;
  logic [3:0]  cmd_mask;
  logic [15:0] cmd_len;
  logic        in_vld;
  logic        in_accept_o;
  logic        pipe_out_vld;
  logic [3:0]  stage_en_o;
  logic        busy_o;
  logic        done_o;
  logic        err_protocol_o;
  logic        err_timeout_o;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Behavioural model of the active command.
  int       m_ph;
  int       m_len;
  int       m_ins;
  int       m_outs;
  int       m_idle;
  logic [3:0] m_mask;
  logic     m_ep;
  logic     m_et;

  // Event bookkeeping for the hand-computed latency pins.
  int   acc_cyc   = 0;
  int   done_cyc  = 0;
  int   seen_in   = 0;
  logic done_evt  = 1'b0;
  logic done_errp = 1'b0;
  logic done_errt = 1'b0;

  vpu_pathway_sequencer #(
    .NUM_STAGES(4),
    .CNT_W     (16),
    .TIMEOUT   (TO)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_cmd_valid   (cmd_valid),
    .o_cmd_ready   (cmd_ready_o),
    .i_cmd_mask    (cmd_mask),
    .i_cmd_len     (cmd_len),
    .i_in_vld      (in_vld),
    .o_in_accept   (in_accept_o),
    .i_pipe_out_vld(pipe_out_vld),
    .o_stage_en    (stage_en_o),
    .o_busy        (busy_o),
    .o_done        (done_o),
    .o_err_protocol(err_protocol_o),
    .o_err_timeout (err_timeout_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Apply one cycle of inputs, then return just after the rising edge.
  task automatic drive(input logic cv, input logic [3:0] m, input logic [15:0] l,
                       input logic iv, input logic pv);
    cmd_valid    = cv;
    cmd_mask     = m;
    cmd_len      = l;
    in_vld       = iv;
    pipe_out_vld = pv;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int max_cyc);
    int i;
    i = 0;
    while (!done_evt && (i < max_cyc)) begin
      drive(1'b0, 4'd0, 16'd0, 1'b0, 1'b0);
      i = i + 1;
    end
    chk("done_seen", {31'd0, done_evt}, 32'd1);
  endtask

  // Compare process: predict outputs from the model, compare, then advance.
  initial begin
    logic e_acc;
    logic e_in;
    logic e_out;
    forever begin
      @(negedge clk);
      cyc = cyc + 1;
      if (rst) begin
        chk("rst_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
        chk("rst_busy",      {31'd0, busy_o},      32'd0);
        chk("rst_done",      {31'd0, done_o},      32'd0);
        chk("rst_stage_en",  {28'd0, stage_en_o},  32'd0);
        chk("rst_err_prot",  {31'd0, err_protocol_o}, 32'd0);
        chk("rst_err_tmo",   {31'd0, err_timeout_o},  32'd0);
        chk("rst_in_accept", {31'd0, in_accept_o}, 32'd0);
        m_ph = P_IDLE; m_len = 0; m_ins = 0; m_outs = 0; m_idle = 0;
        m_mask = 4'd0; m_ep = 1'b0; m_et = 1'b0;
      end else begin
        e_acc = cmd_valid && (m_ph == P_IDLE);
        e_in  = in_vld && (m_ph == P_RUN) && (m_ins < m_len);
        e_out = pipe_out_vld && ((m_ph == P_RUN) || (m_ph == P_DRAIN)) && (m_outs < m_len);
        chk("cmd_ready", {31'd0, cmd_ready_o}, {31'd0, (m_ph == P_IDLE)});
        chk("busy",      {31'd0, busy_o},      {31'd0, (m_ph != P_IDLE)});
        chk("done",      {31'd0, done_o},      {31'd0, (m_ph == P_DONE)});
        chk("in_accept", {31'd0, in_accept_o}, {31'd0, e_in});
        chk("stage_en",  {28'd0, stage_en_o},  {28'd0, m_mask});
        chk("err_prot",  {31'd0, err_protocol_o}, {31'd0, m_ep});
        chk("err_tmo",   {31'd0, err_timeout_o},  {31'd0, m_et});

        if (in_accept_o) seen_in = seen_in + 1;
        if (done_o) begin
          done_cyc  = cyc;
          done_errp = err_protocol_o;
          done_errt = err_timeout_o;
          done_evt  = 1'b1;
        end

        if (e_acc) begin
          m_len  = int'(cmd_len);
          m_mask = cmd_mask;
          m_ins  = 0; m_outs = 0; m_idle = 0;
          m_ep   = 1'b0; m_et = 1'b0;
          m_ph   = (cmd_len == 16'd0) ? P_DONE : P_RUN;
          acc_cyc = cyc;
          seen_in = 0;
        end else begin
          if ((in_vld && !e_in) || (pipe_out_vld && !e_out)) m_ep = 1'b1;
          case (m_ph)
            P_RUN: begin
              if (e_in)  m_ins  = m_ins + 1;
              if (e_out) m_outs = m_outs + 1;
              if (m_outs == m_len)     m_ph = P_DONE;
              else if (m_ins == m_len) m_ph = P_DRAIN;
            end
            P_DRAIN: begin
              if (pipe_out_vld) begin
                m_idle = 0;
                if (e_out) m_outs = m_outs + 1;
                if (m_outs == m_len) m_ph = P_DONE;
              end else if (m_idle == TO - 1) begin
                m_ph = P_DONE;
                m_et = 1'b1;
              end else begin
                m_idle = m_idle + 1;
              end
            end
            P_DONE: begin
              m_ph   = P_IDLE;
              m_mask = 4'd0;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Stimulus.
  initial begin
    int dens;
    logic cv;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_mask = 4'd0; cmd_len = 16'd0; in_vld = 1'b0; pipe_out_vld = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, 4'd0, 16'd0, 1'b0, 1'b0);

    // Nominal run: mask 0011, len 3, inputs cycles 1-3, outputs cycles 3-5.
    done_evt = 1'b0;
    drive(1'b1, 4'b0011, 16'd3, 1'b0, 1'b0);
    chk("t2_stage_en", {28'd0, stage_en_o}, 32'h3);
    drive(1'b0, 4'd0, 16'd0, 1'b1, 1'b0);
    drive(1'b0, 4'd0, 16'd0, 1'b1, 1'b0);
    drive(1'b0, 4'd0, 16'd0, 1'b1, 1'b1);
    drive(1'b0, 4'd0, 16'd0, 1'b0, 1'b1);
    drive(1'b0, 4'd0, 16'd0, 1'b0, 1'b1);
    wait_done(20);
    chk("t2_latency", done_cyc - acc_cyc, 32'd6);
    chk("t2_accepts", seen_in, 32'd3);
    chk("t2_errp", {31'd0, done_errp}, 32'd0);
    chk("t2_errt", {31'd0, done_errt}, 32'd0);
    chk("t2_stage_en_after", {28'd0, stage_en_o}, 32'd0);

    // Empty command.
    done_evt = 1'b0;
    drive(1'b1, 4'b1010, 16'd0, 1'b0, 1'b0);
    chk("t3_busy", {31'd0, busy_o}, 32'd1);
    chk("t3_stage_en_done", {28'd0, stage_en_o}, 32'ha);
    wait_done(5);
    chk("t3_latency", done_cyc - acc_cyc, 32'd1);
    chk("t3_busy_after", {31'd0, busy_o}, 32'd0);
    chk("t3_stage_en_after", {28'd0, stage_en_o}, 32'd0);

    // Overrun: len 2, three input offers.
    done_evt = 1'b0;
    drive(1'b1, 4'b0101, 16'd2, 1'b0, 1'b0);
    drive(1'b0, 4'd0, 16'd0, 1'b1, 1'b0);
    drive(1'b0, 4'd0, 16'd0, 1'b1, 1'b0);
    drive(1'b0, 4'd0, 16'd0, 1'b1, 1'b0);
    drive(1'b0, 4'd0, 16'd0, 1'b0, 1'b1);
    drive(1'b0, 4'd0, 16'd0, 1'b0, 1'b1);
    wait_done(20);
    chk("t4_latency", done_cyc - acc_cyc, 32'd6);
    chk("t4_accepts", seen_in, 32'd2);
    chk("t4_errp_at_done", {31'd0, done_errp}, 32'd1);
    chk("t4_errp_sticky", {31'd0, err_protocol_o}, 32'd1);

    // Watchdog: len 2, a single output beat.
    done_evt = 1'b0;
    drive(1'b1, 4'b1111, 16'd2, 1'b0, 1'b0);
    chk("t4_errp_cleared", {31'd0, err_protocol_o}, 32'd0);
    drive(1'b0, 4'd0, 16'd0, 1'b1, 1'b0);
    drive(1'b0, 4'd0, 16'd0, 1'b1, 1'b1);
    wait_done(30);
    chk("t5_latency", done_cyc - acc_cyc, 32'd11);
    chk("t5_errt", {31'd0, done_errt}, 32'd1);
    chk("t5_errp", {31'd0, done_errp}, 32'd0);

    // Pass-through: mask 0, len 4, in and out together.
    done_evt = 1'b0;
    drive(1'b1, 4'b0000, 16'd4, 1'b0, 1'b0);
    repeat (4) drive(1'b0, 4'd0, 16'd0, 1'b1, 1'b1);
    chk("t6_done_now", {31'd0, done_o}, 32'd1);
    wait_done(5);
    chk("t6_latency", done_cyc - acc_cyc, 32'd5);
    chk("t6_accepts", seen_in, 32'd4);
    chk("t6_errp", {31'd0, done_errp}, 32'd0);

    // Reset mid-RUN takes effect without a clock edge.
    drive(1'b1, 4'b0110, 16'd5, 1'b0, 1'b0);
    drive(1'b0, 4'd0, 16'd0, 1'b1, 1'b0);
    drive(1'b0, 4'd0, 16'd0, 1'b1, 1'b0);
    in_vld = 1'b0;
    rst = 1'b1;
    #1;
    chk("t1_busy", {31'd0, busy_o}, 32'd0);
    chk("t1_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
    chk("t1_stage_en", {28'd0, stage_en_o}, 32'd0);
    chk("t1_done", {31'd0, done_o}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, 4'd0, 16'd0, 1'b0, 1'b0);

    // Randomized traffic with varying beat density and rare resets.
    dens = 5;
    for (int c = 0; c < 4000; c++) begin
      if ((c % 40) == 0) dens = $urandom_range(1, 9);
      if ($urandom_range(0, 799) == 0) begin
        rst = 1'b1;
        drive(1'b0, 4'd0, 16'd0, 1'b0, 1'b0);
        rst = 1'b0;
      end
      cv = ($urandom_range(0, 3) == 0);
      if (cv) begin
        drive(1'b1, 4'($urandom_range(0, 15)), 16'($urandom_range(0, 6)), 1'b0, 1'b0);
      end else begin
        drive(1'b0, 4'd0, 16'd0,
              ($urandom_range(0, 9) < dens), ($urandom_range(0, 9) < dens));
      end
    end
    drive(1'b0, 4'd0, 16'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
